// File: rtl/sort_seq_ctrl.sv
// sort_seq_ctrl: loads N words into an external single-port RAM, bubble-sorts them in place
// (ascending, stable, early exit on a clean pass), then streams them out.
module sort_seq_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam int N = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LAST_PASS = ADDR_W'(N - 2);

    typedef enum logic [2:0] {LOAD, RD_A, RD_B, WR_A, WR_B, ADV, OUT} state_t;

    state_t            state, nxt;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, j, pass, last_j;
    logic              swapped, done;
    logic [DATA_W-1:0] tmp_a, tmp_b;

    assign out_data = ram_dout;
    assign last_j   = LAST_PASS - pass;
    assign done     = !swapped || pass == LAST_PASS;

    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = j;
        ram_din   = tmp_b;
        busy      = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                ram_addr = wr_ptr;
                ram_din  = in_data;
                ram_we   = in_valid;
                nxt      = (in_valid && wr_ptr == LAST) ? RD_A : LOAD;
            end
            RD_A: nxt = RD_B;
            RD_B: begin
                ram_addr = j + 1'b1;
                nxt      = (tmp_a > ram_dout) ? WR_A : ADV;
            end
            WR_A: begin
                ram_we = 1'b1;
                nxt    = WR_B;
            end
            WR_B: begin
                ram_we   = 1'b1;
                ram_addr = j + 1'b1;
                ram_din  = tmp_a;
                nxt      = ADV;
            end
            ADV: nxt = (j < last_j || !done) ? RD_A : OUT;
            OUT: begin
                ram_addr  = rd_ptr;
                out_valid = 1'b1;
                out_last  = rd_ptr == LAST;
                nxt       = (out_ready && out_last) ? LOAD : OUT;
            end
            default: nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOAD;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            j       <= '0;
            pass    <= '0;
            swapped <= 1'b0;
            tmp_a   <= '0;
            tmp_b   <= '0;
        end else begin
            state <= nxt;
            case (state)
                LOAD: if (in_valid) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (wr_ptr == LAST) begin
                        j       <= '0;
                        pass    <= '0;
                        swapped <= 1'b0;
                    end
                end
                RD_A: tmp_a <= ram_dout;
                RD_B: tmp_b <= ram_dout;
                WR_B: swapped <= 1'b1;
                ADV: begin
                    if (j < last_j) begin
                        j <= j + 1'b1;
                    end else if (done) begin
                        rd_ptr <= '0;
                    end else begin
                        pass    <= pass + 1'b1;
                        j       <= '0;
                        swapped <= 1'b0;
                    end
                end
                OUT: if (out_ready) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if (rd_ptr == LAST) wr_ptr <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_seq_ctrl.sv
// tb_sort_seq_ctrl: directed jobs through the sort controller with a behavioural RAM.
module tb_sort_seq_ctrl;
    localparam int AW = 3;
    localparam int DW = 16;
    localparam int N = 8;

    logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_last, busy, ram_we;
    logic [DW-1:0] out_data, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] mem [N];

    sort_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
    end
    assign ram_dout = mem[ram_addr];

    typedef struct packed {
        logic [0:7][DW-1:0] din;
        logic [0:7][DW-1:0] dout;
        logic [15:0]        cyc;
        logic [15:0]        wr;
        logic               stress;
    } vec_t;

    vec_t tv [5];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stress jobs insert input gaps, hold in_valid/out_ready high while sorting
    // (both must be ignored) and toggle out_ready 1010 during output.
    task automatic run_job(input vec_t v, input int id);
        int k = 0, g = 0, cyc = 0, wr = 0, m = 0, t = 0;
        bit tog = 1'b1, stall = 1'b0;
        logic [DW-1:0] held = '0;
        while (k < N && t < 200) begin
            @(negedge clk);
            t++;
            in_valid = !(v.stress && (g % 3 == 2));
            g++;
            in_data = v.din[k];
            #1;
            if (in_valid && in_ready) k++;
        end
        chk($sformatf("v%0d_load", id), k, N);
        @(negedge clk);
        in_valid = v.stress;
        in_data = 16'hDEAD;
        out_ready = v.stress;
        #1;
        t = 0;
        while (!out_valid && t < 1000) begin
            if (busy) cyc++;
            if (ram_we) wr++;
            @(negedge clk);
            #1;
            t++;
        end
        chk($sformatf("v%0d_sort_cycles", id), cyc, v.cyc);
        chk($sformatf("v%0d_sort_writes", id), wr, v.wr);
        in_valid = 1'b0;
        t = 0;
        while (m < N && t < 200) begin
            if (stall) chk($sformatf("v%0d_stall_hold", id), {out_valid, out_data}, {1'b1, held});
            out_ready = v.stress ? tog : 1'b1;
            tog = !tog;
            if (out_valid && out_ready) begin
                chk($sformatf("v%0d_word%0d", id, m), out_data, v.dout[m]);
                chk($sformatf("v%0d_last%0d", id, m), out_last, m == N - 1);
                m++;
            end
            stall = out_valid && !out_ready;
            held = out_data;
            @(negedge clk);
            #1;
            t++;
        end
        chk($sformatf("v%0d_out_count", id), m, N);
        out_ready = 1'b0;
        chk($sformatf("v%0d_back_to_load", id), {in_ready, busy, out_valid}, 3'b100);
    endtask

    initial begin
        int t;
        tv[0] = {{16'd3, 16'd1, 16'd2, 16'd0, 16'd7, 16'd6, 16'd5, 16'd4},
                 {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7}, 16'd88, 16'd22, 1'b0};
        tv[1] = {{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8},
                 {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8}, 16'd21, 16'd0, 1'b0};
        tv[2] = {{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                 {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8}, 16'd140, 16'd56, 1'b0};
        tv[3] = {{16'd5, 16'd5, 16'hFFFF, 16'd0, 16'd5, 16'd1, 16'hFFFF, 16'd0},
                 {16'd0, 16'd0, 16'd1, 16'd5, 16'd5, 16'd5, 16'hFFFF, 16'hFFFF}, 16'd112, 16'd28, 1'b1};
        tv[4] = {{16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2},
                 {16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2}, 16'd21, 16'd0, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_busy", busy, 0);

        // Abort a reverse-order job on its first swap write, then start fresh.
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = DW'(N - k);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        t = 0;
        while (!(busy && ram_we) && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("abort_wr_a_reached", busy && ram_we, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk("abort_state", {in_ready, busy, out_valid, ram_we}, 4'b1000);

        for (int i = 0; i < 5; i++) run_job(tv[i], i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
